timer_channel: RTL and testbench
================================

TIMER_CHANNEL -- requirements
Module: timer_channel

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter/count-register width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cs, input, 1, chip select; load is ignored while cs=0.
REQ-005 SHALL have port load, input, 1, one-cycle write strobe; latches mode and count_in.
REQ-006 SHALL have port mode, input, 3, operating mode 0-5; 6/7 alias to 2/3.
REQ-007 SHALL have port count_in, input, WIDTH, initial count value.
REQ-008 SHALL have port gate, input, 1, gate, synchronous to clk.
REQ-009 SHALL have port out, output, 1, timer output.
REQ-010 SHALL have port current_count, output, WIDTH, counting element (CE) value.
REQ-011 SHALL have port null_count, output, 1, high from accepted load until CR is transferred to CE.

Function
REQ-012 Accepted load (cs=1, load=1) SHALL latch mode into mode register and count_in into count register (CR), and set null_count=1.
REQ-013 Accepted load SHALL immediately (same edge) drive out to 0 in mode 0, otherwise to 1, and stop counting until the mode's start condition.
REQ-014 CR=0 SHALL mean 2^WIDTH; in modes 2/3, CR=1 SHALL behave as CR=2.
REQ-015 Gate trigger SHALL be a rising edge: gate=1 this cycle and gate=0 in the previous cycle (registered gate_q).
REQ-016 Mode 0 (interrupt on TC): CE=CR on the edge after load; CE decrements each cycle while gate=1; out goes 1 on the edge CE reaches 0 (N+1 cycles after load with gate high); out stays 1 until next load; CE wraps and keeps counting.
REQ-017 Mode 1 (retriggerable one-shot): out=1 after load; on trigger, CE=CR and out=0 on the next edge; decrement each cycle regardless of gate; out=1 when CE reaches 0; a retrigger mid-count reloads CE=CR with out held 0.
REQ-018 Mode 2 (rate generator): CE=CR the edge after load; decrement while gate=1; out=0 for exactly one cycle when CE=1, then CE=CR, out=1; period N cycles.
REQ-019 Mode 3 (square wave): same reload cadence as mode 2; out high for ceil(N/2) cycles and low for floor(N/2) cycles per period, toggling at each half-period boundary.
REQ-020 Modes 2/3: gate=0 SHALL hold CE and force out=1 on the next edge; trigger SHALL reload CE=CR and restart the period.
REQ-021 Mode 4 (software strobe): CE=CR the edge after load; decrement while gate=1; out=0 for one cycle when CE reaches 0, then 1; no reload, CE wraps.
REQ-022 Mode 5 (hardware strobe): trigger loads CE=CR; decrement each cycle; out=0 for one cycle when CE reaches 0; retrigger reloads.
REQ-023 null_count SHALL clear on the edge CR is transferred to CE.
REQ-024 New load during counting in modes 2/3 SHALL take effect at the next reload; in modes 0/4 it SHALL restart per REQ-013; in modes 1/5 it SHALL take effect at the next trigger.
REQ-025 Load and trigger in the same cycle: load SHALL win; the trigger is discarded.
REQ-026 Decrement SHALL be modulo 2^WIDTH (0 -> all ones).

Reset
REQ-027 rst SHALL asynchronously set out=0, current_count=0, CR=0, mode register=0, null_count=0, gate_q=0, and the channel idle (no counting) until an accepted load.
REQ-028 Deassertion SHALL require no further initialisation; rst mid-count SHALL abandon the count.

Structure
REQ-029 Mode encodings MODE_INT_TC..MODE_HW_STROBE and the counter state enum (IDLE, WAIT_LOAD, COUNTING, WAIT_TRIG) SHALL live in shared package timer_pkg.
REQ-030 Gate edge detection SHALL be sub-module gate_edge_detect; all else SHALL be in timer_channel.

Verification
REQ-031 Mode 0, CR=3, gate=1: out=0 at load, rises exactly 4 cycles after load, stays 1.
REQ-032 Mode 1, CR=5: trigger -> out=0 for 5 cycles; retrigger at cycle 3 -> out low for 3+5 cycles total.
REQ-033 Mode 2, CR=4: out low 1 cycle every 4; gate low 2 cycles -> out=1 and CE held; gate rise restarts period.
REQ-034 Mode 3, CR=5: out high 3 cycles, low 2, repeating; CR=4 -> 2/2.
REQ-035 Mode 4/5, CR=0, WIDTH=4: strobe after 16 cycles; load with cs=0 -> no effect.
REQ-036 rst asserted mid-count in mode 2 -> out=0, current_count=0 immediately, no strobe after release until new load.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared mode encodings, counter state enum and mode decode for the timer channel.
package timer_pkg;

  typedef enum logic [2:0] {
    MODE_INT_TC    = 3'd0,
    MODE_ONESHOT   = 3'd1,
    MODE_RATE      = 3'd2,
    MODE_SQUARE    = 3'd3,
    MODE_SW_STROBE = 3'd4,
    MODE_HW_STROBE = 3'd5
  } timer_mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COUNTING  = 2'd2,
    WAIT_TRIG = 2'd3
  } cnt_state_e;

  // Codes 6/7 fold onto rate generator / square wave.
  function automatic timer_mode_e eff_mode(input logic [2:0] m);
    return (m[2:1] == 2'b11) ? timer_mode_e'({1'b0, m[1:0]}) : timer_mode_e'(m);
  endfunction

endpackage

// File: rtl/gate_edge_detect.sv
// Registers the gate and flags its rising edge as the channel trigger.
module gate_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_gate,
  output logic o_rise
);

  logic r_gate_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gate_q <= 1'b0;
    else     r_gate_q <= i_gate;
  end

  assign o_rise = i_gate & ~r_gate_q;

endmodule

// File: rtl/timer_channel.sv
// One programmable timer channel: six counting modes, gate triggering and
// count-register reprogramming while running.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] count_in,
  input  logic             gate,
  output logic             out,
  output logic [WIDTH-1:0] current_count,
  output logic             null_count
);

  timer_mode_e      r_mode;
  cnt_state_e       r_state;
  logic [WIDTH-1:0] r_cr;
  logic [WIDTH-1:0] r_ce;
  logic [WIDTH-1:0] r_half;
  logic             r_out;
  logic             r_null;
  logic             r_armed;

  logic             w_rise;
  logic             w_load;
  logic             w_trig;
  timer_mode_e      w_new_mode;
  logic             w_soft;
  logic             w_restart;
  logic [WIDTH-1:0] w_reload;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_dec;
  logic             w_tc;

  gate_edge_detect u_gate (
    .clk    (clk),
    .rst    (rst),
    .i_gate (gate),
    .o_rise (w_rise)
  );

  assign w_load     = cs & load;
  assign w_trig     = w_rise & ~w_load;
  assign w_new_mode = eff_mode(mode);

  // Same-mode rewrites in the periodic / triggered modes only update CR;
  // the running count is left alone until the next reload or trigger.
  assign w_soft = (w_new_mode == r_mode) && (r_state == COUNTING) &&
                  (r_mode inside {MODE_ONESHOT, MODE_RATE, MODE_SQUARE, MODE_HW_STROBE});
  assign w_restart = w_load & ~w_soft;

  assign w_reload = ((r_mode inside {MODE_RATE, MODE_SQUARE}) && (r_cr == WIDTH'(1)))
                    ? WIDTH'(2) : r_cr;
  // CR=0 stands for 2^WIDTH, whose half is the top bit alone.
  assign w_half   = (w_reload == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : (w_reload >> 1);
  assign w_dec    = r_ce - WIDTH'(1);
  assign w_tc     = (r_ce == WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_INT_TC;
      r_state <= IDLE;
      r_cr    <= '0;
      r_ce    <= '0;
      r_half  <= '0;
      r_out   <= 1'b0;
      r_null  <= 1'b0;
      r_armed <= 1'b0;
    end else if (w_restart) begin
      r_mode  <= w_new_mode;
      r_cr    <= count_in;
      r_null  <= 1'b1;
      r_armed <= 1'b0;
      r_out   <= (w_new_mode != MODE_INT_TC);
      r_state <= (w_new_mode inside {MODE_ONESHOT, MODE_HW_STROBE}) ? WAIT_TRIG : WAIT_LOAD;
    end else begin
      case (r_state)
        WAIT_LOAD: begin
          r_ce    <= w_reload;
          r_half  <= w_half;
          r_null  <= 1'b0;
          r_armed <= 1'b1;
          r_state <= COUNTING;
        end
        WAIT_TRIG: begin
          if (w_trig) begin
            r_ce    <= r_cr;
            r_null  <= 1'b0;
            r_armed <= 1'b1;
            r_state <= COUNTING;
            if (r_mode == MODE_ONESHOT) r_out <= 1'b0;
          end
        end
        COUNTING: begin
          case (r_mode)
            MODE_INT_TC: begin
              if (gate) begin
                r_ce <= w_dec;
                if (w_tc) r_out <= 1'b1;
              end
            end
            MODE_SW_STROBE: begin
              r_out <= ~(gate & w_tc & r_armed);
              if (gate) begin
                r_ce <= w_dec;
                if (w_tc) r_armed <= 1'b0;
              end
            end
            MODE_ONESHOT, MODE_HW_STROBE: begin
              if (w_trig) begin
                r_ce    <= r_cr;
                r_null  <= 1'b0;
                r_armed <= 1'b1;
                r_out   <= (r_mode != MODE_ONESHOT);
              end else begin
                r_ce <= w_dec;
                if (w_tc) r_armed <= 1'b0;
                if (r_mode == MODE_ONESHOT) begin
                  if (w_tc & r_armed) r_out <= 1'b1;
                end else begin
                  r_out <= ~(w_tc & r_armed);
                end
              end
            end
            default: begin
              // Rate generator and square wave share the reload cadence.
              if (w_trig || (gate && w_tc)) begin
                r_ce   <= w_reload;
                r_half <= w_half;
                r_null <= 1'b0;
                r_out  <= 1'b1;
              end else if (!gate) begin
                r_out <= 1'b1;
              end else begin
                r_ce  <= w_dec;
                r_out <= (r_mode == MODE_RATE) ? (w_dec != WIDTH'(1)) : (w_dec > r_half);
              end
            end
          endcase
        end
        default: ;
      endcase
      // A rewrite that was not transferred this edge keeps null_count high.
      if (w_load) begin
        r_cr   <= count_in;
        r_null <= 1'b1;
      end
    end
  end

  assign out           = r_out;
  assign current_count = r_ce;
  assign null_count    = r_null;

endmodule

// File: tb/tb_timer_channel.sv
// Scoreboard bench for timer_channel: expected out/null/count are queued with
// each driven cycle and compared just after the following rising edge.
module tb_timer_channel;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         cs;
  logic         load;
  logic [2:0]   mode;
  logic [W-1:0] count_in;
  logic         gate;
  logic         out;
  logic [W-1:0] current_count;
  logic         null_count;

  typedef struct {
    string tag;
    int    o;
    int    n;
    int    c;
  } exp_t;

  exp_t  sb[$];
  exp_t  cur;
  string cur_tag;
  int    n_chk;
  int    n_bad;

  timer_channel #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cs            (cs),
    .load          (load),
    .mode          (mode),
    .count_in      (count_in),
    .gate          (gate),
    .out           (out),
    .current_count (current_count),
    .null_count    (null_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue the expected post-edge state, then wait for the next drive point.
  task automatic tick(input int eo, input int en, input int ec);
    exp_t e;
    e.tag = cur_tag;
    e.o   = eo;
    e.n   = en;
    e.c   = ec;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.tag, "_out"}, 32'(out), cur.o);
      if (cur.n >= 0) chk({cur.tag, "_null"}, 32'(null_count), cur.n);
      if (cur.c >= 0) chk({cur.tag, "_ce"}, 32'(current_count), cur.c);
    end
  end

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1; cs = 1'b0; load = 1'b0; mode = 3'd0; count_in = '0; gate = 1'b0;
    cur_tag = "init";
    #3;
    chk("rst_out", 32'(out), 0);
    chk("rst_ce", 32'(current_count), 0);
    chk("rst_null", 32'(null_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, CR=3: out low at load, rises 4 edges later, then holds
    cur_tag = "m0";
    gate = 1'b1; cs = 1'b1; load = 1'b1; mode = 3'd0; count_in = 4'd3;
    tick(0, 1, 0);
    load = 1'b0; cs = 1'b0;
    tick(0, 0, 3); tick(0, 0, 2); tick(0, 0, 1); tick(1, 0, 0);
    tick(1, 0, 15); tick(1, 0, 14);

    // Mode 1, CR=5: 5-cycle pulse, then retrigger at cycle 3 gives 8
    cur_tag = "m1";
    gate = 1'b0; cs = 1'b1; load = 1'b1; mode = 3'd1; count_in = 4'd5;
    tick(1, 1, -1);
    load = 1'b0;
    tick(1, 1, -1);
    gate = 1'b1;
    tick(0, 0, 5); tick(0, 0, 4); tick(0, 0, 3); tick(0, 0, 2); tick(0, 0, 1);
    tick(1, 0, 0); tick(1, 0, 15);
    gate = 1'b0; tick(1, 0, 14);
    gate = 1'b1; tick(0, 0, 5); tick(0, 0, 4);
    gate = 1'b0; tick(0, 0, 3);
    gate = 1'b1;
    tick(0, 0, 5); tick(0, 0, 4); tick(0, 0, 3); tick(0, 0, 2); tick(0, 0, 1);
    tick(1, 0, 0);

    // Mode 2, CR=4: one low cycle per 4; gate low holds; rewrite at reload
    cur_tag = "m2";
    cs = 1'b1; load = 1'b1; mode = 3'd2; count_in = 4'd4;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    tick(1, 0, 4); tick(1, 0, 3); tick(1, 0, 2); tick(0, 0, 1);
    tick(1, 0, 4); tick(1, 0, 3); tick(1, 0, 2); tick(0, 0, 1);
    tick(1, 0, 4); tick(1, 0, 3);
    gate = 1'b0; tick(1, 0, 3); tick(1, 0, 3);
    gate = 1'b1; tick(1, 0, 4); tick(1, 0, 3); tick(1, 0, 2); tick(0, 0, 1); tick(1, 0, 4);
    cs = 1'b1; load = 1'b1; mode = 3'd2; count_in = 4'd3;
    tick(1, 1, 3);
    load = 1'b0; cs = 1'b0;
    tick(1, 1, 2); tick(0, 1, 1); tick(1, 0, 3); tick(1, 0, 2); tick(0, 0, 1); tick(1, 0, 3);

    // Mode 3: CR=5 gives 3 high / 2 low, rewrite to CR=4 gives 2 / 2
    cur_tag = "m3";
    cs = 1'b1; load = 1'b1; mode = 3'd3; count_in = 4'd5;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    tick(1, 0, 5); tick(1, 0, 4); tick(1, 0, 3); tick(0, 0, 2); tick(0, 0, 1);
    tick(1, 0, 5); tick(1, 0, 4); tick(1, 0, 3); tick(0, 0, 2); tick(0, 0, 1);
    tick(1, 0, 5);
    cs = 1'b1; load = 1'b1; mode = 3'd3; count_in = 4'd4;
    tick(1, 1, 4);
    load = 1'b0; cs = 1'b0;
    tick(1, 1, 3); tick(0, 1, 2); tick(0, 1, 1);
    tick(1, 0, 4); tick(1, 0, 3); tick(0, 0, 2); tick(0, 0, 1); tick(1, 0, 4);

    // Mode 4, CR=0 (16 counts); a load with cs=0 mid-count is ignored
    cur_tag = "m4";
    cs = 1'b1; load = 1'b1; mode = 3'd4; count_in = 4'd0;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        load = 1'b1; mode = 3'd0; count_in = 4'd5;
      end else begin
        load = 1'b0;
      end
      tick((k == 17) ? 0 : 1, 0, (1 - k) & 15);
    end
    load = 1'b0;

    // Mode 5, CR=0: strobe 16 edges after the trigger
    cur_tag = "m5";
    gate = 1'b0; cs = 1'b1; load = 1'b1; mode = 3'd5; count_in = 4'd0;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    tick(1, 1, -1);
    gate = 1'b1;
    tick(1, 0, 0);
    for (int j = 1; j <= 18; j++) tick((j == 16) ? 0 : 1, 0, (-j) & 15);

    // Load coinciding with a gate rise: the trigger is dropped
    cur_tag = "ldtrig";
    gate = 1'b0; tick(1, 0, -1);
    cs = 1'b1; load = 1'b1; mode = 3'd5; count_in = 4'd3; gate = 1'b1;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    tick(1, 1, -1);
    gate = 1'b0; tick(1, 1, -1);
    gate = 1'b1;
    tick(1, 0, 3); tick(1, 0, 2); tick(1, 0, 1); tick(0, 0, 0); tick(1, 0, 15);

    // Reset mid-count in mode 2: immediate clear, silent until reloaded
    cur_tag = "rst";
    cs = 1'b1; load = 1'b1; mode = 3'd2; count_in = 4'd4; gate = 1'b1;
    tick(1, 1, -1);
    load = 1'b0; cs = 1'b0;
    tick(1, 0, 4); tick(1, 0, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_out", 32'(out), 0);
    chk("async_ce", 32'(current_count), 0);
    chk("async_null", 32'(null_count), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gate = i[0];
      tick(0, 0, 0);
    end
    cur_tag = "reload";
    gate = 1'b1; cs = 1'b1; load = 1'b1; mode = 3'd2; count_in = 4'd4;
    tick(1, 1, 0);
    load = 1'b0; cs = 1'b0;
    tick(1, 0, 4); tick(1, 0, 3);

    @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
